fifo_wr_skid: RTL and testbench

// Write-side adapter for a standard (non-FWFT) synchronous FIFO. It is the producer end of the

---
 rtl/fifo_wr_skid.sv | 133 +++++++++++++
 tb/tb_fifo_wr_skid.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_skid.sv
// fifo_wr_skid: write-side adapter for a standard synchronous FIFO.
// Turns an upstream valid/ready stream into wr_en/wr_data, using a
// 2-entry skid buffer so that in_ready is a registered signal while
// still sustaining one word per clock whenever the FIFO has room.
module fifo_wr_skid #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  // Encoding is {out_valid, skid_valid}; the (0,1) combination is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic out_valid;
  logic skid_valid;
  logic accept;
  logic drain;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid_from_in;

  assign out_valid  = state_q[1];
  assign skid_valid = state_q[0];

  // Ready depends only on held state, never on in_valid.
  assign in_ready   = ~skid_valid;
  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & ~fifo_full;

  assign fifo_wr_en   = drain;
  assign fifo_wr_data = out_data_q;
  assign busy         = out_valid | skid_valid;
  assign word_cnt     = cnt_q;

  // Next-state and data-steering decode; flush overrides every transition.
  always_comb begin
    state_d            = state_q;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid_from_in  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d          = ONE;
            load_out_from_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            state_d          = ONE;
            load_out_from_in = 1'b1;
          end else if (accept) begin
            state_d           = FULL;
            load_skid_from_in = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d            = ONE;
            load_out_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Buffer entries: output register and skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      if (load_out_from_in) begin
        out_data_q <= in_data;
      end else if (load_out_from_skid) begin
        out_data_q <= skid_data_q;
      end
      if (load_skid_from_in) begin
        skid_data_q <= in_data;
      end
    end
  end

  // Written-word counter; a write in a flush cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_wr_skid.sv
// Self-checking bench for fifo_wr_skid: a queue-based model of the held
// words is compared every cycle, plus directed literal checks.
module tb_fifo_wr_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        fifo_full = 1'b0;

  logic        in_ready, fifo_wr_en, busy;
  logic [31:0] fifo_wr_data;
  logic [15:0] word_cnt;

  logic        in_ready4, fifo_wr_en4, busy4;
  logic [31:0] fifo_wr_data4;
  logic [3:0]  word_cnt4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fifo_wr_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .busy(busy), .word_cnt(word_cnt)
  );

  fifo_wr_skid #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en4), .fifo_wr_data(fifo_wr_data4),
    .busy(busy4), .word_cnt(word_cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: the words currently held by the adapter, oldest first.
  logic [31:0] mq[$];
  int unsigned mcnt = 0;
  bit m_wr, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      cyc++;
      m_wr  = (mq.size() > 0) && !fifo_full;
      m_acc = in_valid && (mq.size() < 2);
      if (flush) begin
        mq.delete();
        mcnt = 0;
      end else begin
        if (m_wr) begin
          void'(mq.pop_front());
          mcnt++;
        end
        if (m_acc) mq.push_back(in_data);
      end
    end
  end

  // Log of words seen on the FIFO write port.
  logic [31:0] log_d[$];
  int          log_c[$];

  // Per-cycle comparison against the model (reset state included).
  always @(negedge clk) begin
    bit exp_wr;
    exp_wr = (mq.size() > 0) && !fifo_full;
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("wr_en", 64'(fifo_wr_en), 64'(exp_wr));
    chk("busy", 64'(busy), 64'(mq.size() > 0));
    chk("word_cnt", 64'(word_cnt), 64'(mcnt % 65536));
    chk("word_cnt4", 64'(word_cnt4), 64'(mcnt % 16));
    chk("wr_en4", 64'(fifo_wr_en4), 64'(exp_wr));
    if (exp_wr) chk("wr_data", 64'(fifo_wr_data), 64'(mq[0]));
    if (fifo_wr_en === 1'b1) begin
      log_d.push_back(fifo_wr_data);
      log_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_c.delete();
  endtask

  task automatic check_log(input string name, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2);
    logic [31:0] exp_w[3];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2;
    chk({name, "_len"}, 64'(log_d.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < log_d.size()) begin
        chk({name, "_data"}, 64'(log_d[i]), 64'(exp_w[i]));
        chk({name, "_consec"}, 64'(log_c[i]), 64'(log_c[0] + i));
      end
    end
  endtask

  initial begin
    logic r1, r2;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Test 1: back-to-back pushes with room in the FIFO.
    clear_log();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * (i + 1);
      #3 chk("t1_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check_log("t1", 32'h11, 32'h22, 32'h33);
    chk("t1_cnt", 64'(word_cnt), 64'd3);

    // Test 2: FIFO full, three words offered continuously.
    clear_log();
    fifo_full = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA0;
    step();
    in_data = 32'hA1;
    step();
    in_data = 32'hA2;
    #3 chk("t2_in_ready", 64'(in_ready), 64'd0);
    repeat (2) step();
    chk("t2_no_write", 64'(log_d.size()), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    chk("t2_in_ready_hold", 64'(in_ready), 64'd0);

    // Test 3: release the FIFO; A2 is taken once the skid empties.
    fifo_full = 1'b0;
    step();
    #3 chk("t3_ready_back", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check_log("t3", 32'hA0, 32'hA1, 32'hA2);
    chk("t3_busy", 64'(busy), 64'd0);

    // Test 5: flush from FULL.
    clear_log();
    fifo_full = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hB0;
    step();
    in_data = 32'hB1;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    #3 chk("t5_full_state", 64'(busy), 64'd1);
    step();
    flush = 1'b0;
    #3;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_cnt", 64'(word_cnt), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    fifo_full = 1'b0;
    repeat (3) step();
    chk("t5_no_write", 64'(log_d.size()), 64'd0);

    // Test 6: 17 words into a 4-bit counter, then reset mid-stream.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC00 + i;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("t6_cnt4", 64'(word_cnt4), 64'd1);
    chk("t6_cnt16", 64'(word_cnt), 64'd17);
    in_valid = 1'b1;
    in_data  = 32'hD0;
    step();
    in_data = 32'hD1;
    #1 chk("t6_wr_before", 64'(fifo_wr_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd1);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Test 4: random traffic against the model.
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      fifo_full = ($urandom_range(0, 2) == 0);
      flush     = ($urandom_range(0, 199) == 0);
      if (n % 97 == 0) begin
        #1 r1 = in_ready;
        in_valid = ~in_valid;
        #1 r2 = in_ready;
        in_valid = ~in_valid;
        chk("ready_indep_valid", 64'(r2), 64'(r1));
      end
      step();
    end
    in_valid  = 1'b0;
    fifo_full = 1'b0;
    flush     = 1'b0;
    repeat (4) step();
    chk("end_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
